// File: rtl/pll_lock_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_reset_sequencer
// Description : Debounces a synchronized PLL lock and releases ordered
//               active-low stage resets; re-arms after lock loss.
//               Optional macro PLL_LOCK_LOSS_COUNTER_EN enables a saturating
//               lock-loss event counter on LOCK_LOSS_COUNT.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int NUM_STAGES         = 3,
    parameter int STAGE_GAP_CYCLES   = 16,
    parameter int LOSS_HOLD_CYCLES   = 256
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  PLL_LOCK,
    input  logic                  INIT_DONE,
    output logic [NUM_STAGES-1:0] STAGE_RESET_N,
    output logic                  PLL_READY,
    output logic [2:0]            STATE,
    output logic [7:0]            LOCK_LOSS_COUNT
);

    // One counter serves both the debounce and hold windows.
    localparam int c_CNT_MAX = (LOCK_STABLE_CYCLES > LOSS_HOLD_CYCLES) ?
                               LOCK_STABLE_CYCLES : LOSS_HOLD_CYCLES;
    localparam int c_CNT_W   = (c_CNT_MAX < 2) ? 1 : $clog2(c_CNT_MAX);
    localparam int c_GAP_W   = (STAGE_GAP_CYCLES < 2) ? 1 : $clog2(STAGE_GAP_CYCLES);
    localparam int c_IDX_W   = $clog2(NUM_STAGES + 1);

    localparam logic [c_CNT_W-1:0] c_DEB_LAST  = c_CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(LOSS_HOLD_CYCLES - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST  = c_GAP_W'(STAGE_GAP_CYCLES - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_DONE  = c_IDX_W'(NUM_STAGES);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        DEBOUNCE  = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        HOLD      = 3'd4
    } state_t;

    logic                  r_sync1;
    logic                  r_lock_s;

    state_t                r_state;
    state_t                w_state_next;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_CNT_W-1:0]    w_cnt_next;
    logic [c_GAP_W-1:0]    r_gap;
    logic [c_GAP_W-1:0]    w_gap_next;
    logic [c_IDX_W-1:0]    r_idx;
    logic [c_IDX_W-1:0]    w_idx_next;
    logic [NUM_STAGES-1:0] r_stage_n;
    logic [NUM_STAGES-1:0] w_stage_n_next;
    logic                  r_ready;
    logic                  w_ready_next;

    // PLL_LOCK is asynchronous to CLK.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sync1  <= 1'b0;
            r_lock_s <= 1'b0;
        end else begin
            r_sync1  <= PLL_LOCK;
            r_lock_s <= r_sync1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= WAIT_LOCK;
            r_cnt     <= '0;
            r_gap     <= '0;
            r_idx     <= '0;
            r_stage_n <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_gap     <= w_gap_next;
            r_idx     <= w_idx_next;
            r_stage_n <= w_stage_n_next;
            r_ready   <= w_ready_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_gap_next     = r_gap;
        w_idx_next     = r_idx;
        w_stage_n_next = r_stage_n;
        w_ready_next   = r_ready;

        case (r_state)
            WAIT_LOCK: begin
                w_stage_n_next = '0;
                w_ready_next   = 1'b0;
                if (r_lock_s && INIT_DONE) begin
                    w_state_next = DEBOUNCE;
                    w_cnt_next   = '0;
                end
            end

            DEBOUNCE: begin
                if (!r_lock_s) begin
                    w_state_next = WAIT_LOCK;
                    w_cnt_next   = '0;
                end else if (r_cnt == c_DEB_LAST) begin
                    w_state_next   = RELEASE;
                    w_stage_n_next = NUM_STAGES'(1);
                    w_idx_next     = c_IDX_W'(1);
                    w_gap_next     = '0;
                end else begin
                    w_cnt_next = r_cnt + c_CNT_W'(1);
                end
            end

            RELEASE: begin
                // Lock loss wins over a stage release due on the same edge.
                if (!r_lock_s) begin
                    w_state_next   = HOLD;
                    w_stage_n_next = '0;
                    w_ready_next   = 1'b0;
                    w_cnt_next     = '0;
                end else if (r_idx == c_IDX_DONE) begin
                    w_state_next = RUN;
                    w_ready_next = 1'b1;
                end else if (r_gap == c_GAP_LAST) begin
                    w_stage_n_next = r_stage_n | (NUM_STAGES'(1) << r_idx);
                    w_idx_next     = r_idx + c_IDX_W'(1);
                    w_gap_next     = '0;
                end else begin
                    w_gap_next = r_gap + c_GAP_W'(1);
                end
            end

            RUN: begin
                if (!r_lock_s) begin
                    w_state_next   = HOLD;
                    w_stage_n_next = '0;
                    w_ready_next   = 1'b0;
                    w_cnt_next     = '0;
                end
            end

            HOLD: begin
                // Hold runs to completion even if lock has already returned.
                w_stage_n_next = '0;
                w_ready_next   = 1'b0;
                if (r_cnt == c_HOLD_LAST) begin
                    w_state_next = WAIT_LOCK;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + c_CNT_W'(1);
                end
            end

            default: begin
                w_state_next   = WAIT_LOCK;
                w_cnt_next     = '0;
                w_gap_next     = '0;
                w_idx_next     = '0;
                w_stage_n_next = '0;
                w_ready_next   = 1'b0;
            end
        endcase
    end

    assign STAGE_RESET_N = r_stage_n;
    assign PLL_READY     = r_ready;
    assign STATE         = r_state;

`ifdef PLL_LOCK_LOSS_COUNTER_EN
    logic       w_loss_event;
    logic [7:0] r_loss_cnt;

    assign w_loss_event = (w_state_next == HOLD) && (r_state != HOLD);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_loss_cnt <= 8'd0;
        end else if (w_loss_event && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end

    assign LOCK_LOSS_COUNT = r_loss_cnt;
`else
    assign LOCK_LOSS_COUNT = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_lock_reset_sequencer
// Description : Scoreboard bench with a timestamp-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_reset_sequencer;

    localparam int LSC    = 16;
    localparam int NS     = 3;
    localparam int GAP    = 4;
    localparam int HOLD_C = 8;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          PLL_LOCK;
    logic          INIT_DONE;
    logic [NS-1:0] STAGE_RESET_N;
    logic          PLL_READY;
    logic [2:0]    STATE;
    logic [7:0]    LOCK_LOSS_COUNT;

    pll_lock_reset_sequencer #(
        .LOCK_STABLE_CYCLES (LSC),
        .NUM_STAGES         (NS),
        .STAGE_GAP_CYCLES   (GAP),
        .LOSS_HOLD_CYCLES   (HOLD_C)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .PLL_LOCK        (PLL_LOCK),
        .INIT_DONE       (INIT_DONE),
        .STAGE_RESET_N   (STAGE_RESET_N),
        .PLL_READY       (PLL_READY),
        .STATE           (STATE),
        .LOCK_LOSS_COUNT (LOCK_LOSS_COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int edge_n;
        int stage;
        int ready;
        int state;
        int loss;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: phase number plus the edge on which the phase began;
    // outputs are derived from elapsed edges.
    int   m_mode = 0;
    int   m_t    = 0;
    int   m_e    = 0;
    int   m_loss = 0;
    logic m_lock_hist [2] = '{1'b0, 1'b0};

    task automatic model_edge(input logic r, input logic l, input logic i);
        logic ls;
        int   released;
        exp_t x;
        m_e++;
        if (r) begin
            m_mode = 0;
            m_t    = m_e;
            m_loss = 0;
            m_lock_hist[0] = 1'b0;
            m_lock_hist[1] = 1'b0;
        end else begin
            ls = m_lock_hist[1];
            case (m_mode)
                0: if (ls && i) begin m_mode = 1; m_t = m_e; end
                1: begin
                    if (!ls) begin m_mode = 0; m_t = m_e; end
                    else if (m_e - m_t == LSC) begin m_mode = 2; m_t = m_e; end
                end
                2, 3: begin
                    if (!ls) begin
                        m_mode = 4; m_t = m_e; m_loss++;
                    end else if (m_mode == 2 && (m_e - m_t == (NS - 1) * GAP + 1)) begin
                        m_mode = 3; m_t = m_e;
                    end
                end
                default: if (m_e - m_t == HOLD_C) begin m_mode = 0; m_t = m_e; end
            endcase
            m_lock_hist[1] = m_lock_hist[0];
            m_lock_hist[0] = l;
        end
        x.edge_n = m_e;
        x.state  = m_mode;
        x.ready  = (m_mode == 3) ? 1 : 0;
        if (m_mode == 3) begin
            released = NS;
        end else if (m_mode == 2) begin
            released = 1 + (m_e - m_t) / GAP;
            if (released > NS) released = NS;
        end else begin
            released = 0;
        end
        x.stage = (1 << released) - 1;
`ifdef PLL_LOCK_LOSS_COUNTER_EN
        x.loss = (m_loss > 255) ? 255 : m_loss;
`else
        x.loss = 0;
`endif
        exp_q.push_back(x);
    endtask

    task automatic step(input logic r, input logic l, input logic i);
        RESET     = r;
        PLL_LOCK  = l;
        INIT_DONE = i;
        @(posedge CLK);
        #1;
        model_edge(r, l, i);
    endtask

    task automatic chk(input string name, input int edge_n, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s edge %0d: got %0d expected %0d", name, edge_n, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            chk("stage_reset_n", x.edge_n, int'(STAGE_RESET_N), x.stage);
            chk("pll_ready",     x.edge_n, int'(PLL_READY),     x.ready);
            chk("state",         x.edge_n, int'(STATE),         x.state);
            chk("loss_count",    x.edge_n, int'(LOCK_LOSS_COUNT), x.loss);
        end
    end

    task automatic do_reset();
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        RESET     = 1'b1;
        PLL_LOCK  = 1'b0;
        INIT_DONE = 1'b0;

        // Nominal sequence, then lock loss in RUN with early re-lock.
        do_reset();
        for (int k = 0; k < 40; k++) step(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 2;  k++) step(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 60; k++) step(1'b0, 1'b1, 1'b1);

        // Lock glitch during debounce.
        do_reset();
        for (int k = 0; k < 9;  k++) step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 40; k++) step(1'b0, 1'b1, 1'b1);

        // INIT_DONE gating.
        do_reset();
        for (int k = 0; k < 100; k++) step(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 40;  k++) step(1'b0, 1'b1, 1'b1);

        // Lock loss landing on the stage-1 release edge.
        do_reset();
        for (int k = 0; k < 20; k++) step(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 4;  k++) step(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 40; k++) step(1'b0, 1'b1, 1'b1);

        // RESET asserted mid-RELEASE.
        do_reset();
        for (int k = 0; k < 23; k++) step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 30; k++) step(1'b0, 1'b1, 1'b1);

        // Randomized lock/init/reset traffic.
        do_reset();
        begin
            int n;
            n = 0;
            while (n < 2000) begin
                int   len;
                logic l;
                len = $urandom_range(1, 40);
                l   = ($urandom_range(0, 3) != 0);
                for (int k = 0; k < len; k++) begin
                    step(($urandom_range(0, 299) == 0), l, ($urandom_range(0, 7) != 0));
                end
                n += len;
            end
        end

        // Repeated loss events during RELEASE: exercises counter saturation.
        do_reset();
        for (int ev = 0; ev < 300; ev++) begin
            for (int k = 0; k < 22; k++) step(1'b0, 1'b1, 1'b1);
            for (int k = 0; k < 12; k++) step(1'b0, 1'b0, 1'b1);
        end
        for (int k = 0; k < 40; k++) step(1'b0, 1'b1, 1'b1);

        @(negedge CLK);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
